// File: rtl/station_nav_ctrl.sv
// Mission sequencer: takes GO/STOP commands, drives line-follow enable, halts on
// destination barcode match, and runs the arrival buzzer and the mission timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | stopped; IDs consumed and discarded, timeout counter held at 0
// ST_MOVING | line following toward dest; timeout counter running
module station_nav_ctrl #(
   parameter int TO_W     = 24,
   parameter int BUZZ_CYC = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_rdy,
   input  logic [7:0] cmd,
   output logic       clr_cmd_rdy,
   input  logic       ID_vld,
   input  logic [7:0] ID,
   output logic       clr_ID_vld,
   output logic       go,
   output logic       arrived,
   output logic       buzz,
   output logic       timeout,
   output logic       bad_cmd,
   output logic [5:0] dest
);

   localparam int BZ_W = $clog2(BUZZ_CYC + 1);
   localparam logic [TO_W-1:0] TO_MAX  = '1;
   localparam logic [BZ_W-1:0] BZ_LOAD = BZ_W'(BUZZ_CYC - 1);

   typedef enum logic {ST_IDLE, ST_MOVING} state_t;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [BZ_W-1:0]   buzz_cnt_q, buzz_cnt_d;
   logic              go_q, go_d;
   logic              arrived_q, arrived_d;
   logic              buzz_q, buzz_d;
   logic              timeout_q, timeout_d;
   logic              bad_cmd_q, bad_cmd_d;
   logic [5:0]        dest_q, dest_d;
   logic              clr_cmd_q, clr_id_q;
   logic              cmd_take, id_take, id_match, buzz_start;
   logic              unused_id_hi;

   // The registered clear masks the flag during its own clear cycle.
   assign cmd_take     = cmd_rdy & ~clr_cmd_q;
   assign id_take      = ID_vld & ~clr_id_q;
   assign id_match     = id_take && (ID[5:0] == dest_q);
   assign unused_id_hi = ^ID[7:6];

   always_comb begin
      state_d    = state_q;
      to_cnt_d   = to_cnt_q;
      go_d       = go_q;
      dest_d     = dest_q;
      timeout_d  = timeout_q;
      arrived_d  = 1'b0;
      bad_cmd_d  = 1'b0;
      buzz_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            to_cnt_d = '0;
            if (cmd_take) begin
               unique case (cmd[7:6])
                  2'b01: begin
                     dest_d    = cmd[5:0];
                     go_d      = 1'b1;
                     timeout_d = 1'b0;
                     state_d   = ST_MOVING;
                  end
                  2'b00:   ;
                  default: bad_cmd_d = 1'b1;
               endcase
            end
         end
         ST_MOVING: begin
            to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
            if (cmd_take) begin
               unique case (cmd[7:6])
                  2'b01: begin
                     dest_d   = cmd[5:0];
                     to_cnt_d = '0;
                  end
                  2'b00: begin
                     go_d     = 1'b0;
                     to_cnt_d = '0;
                     state_d  = ST_IDLE;
                  end
                  default: bad_cmd_d = 1'b1;
               endcase
            end else if (id_match) begin
               go_d       = 1'b0;
               arrived_d  = 1'b1;
               buzz_start = 1'b1;
               to_cnt_d   = '0;
               state_d    = ST_IDLE;
            end else if (id_take) begin
               to_cnt_d = '0;
            end else if (to_cnt_q == TO_MAX) begin
               go_d      = 1'b0;
               timeout_d = 1'b1;
               to_cnt_d  = '0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Buzzer: load on arrival (restarting any run in progress), count down to 0.
   always_comb begin
      buzz_cnt_d = buzz_cnt_q;
      buzz_d     = 1'b0;
      if (buzz_start) begin
         buzz_cnt_d = BZ_LOAD;
         buzz_d     = 1'b1;
      end else if (buzz_cnt_q != '0) begin
         buzz_cnt_d = buzz_cnt_q - 1'b1;
         buzz_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         to_cnt_q   <= '0;
         buzz_cnt_q <= '0;
         go_q       <= 1'b0;
         arrived_q  <= 1'b0;
         buzz_q     <= 1'b0;
         timeout_q  <= 1'b0;
         bad_cmd_q  <= 1'b0;
         dest_q     <= '0;
         clr_cmd_q  <= 1'b0;
         clr_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         to_cnt_q   <= to_cnt_d;
         buzz_cnt_q <= buzz_cnt_d;
         go_q       <= go_d;
         arrived_q  <= arrived_d;
         buzz_q     <= buzz_d;
         timeout_q  <= timeout_d;
         bad_cmd_q  <= bad_cmd_d;
         dest_q     <= dest_d;
         clr_cmd_q  <= cmd_take;
         clr_id_q   <= id_take;
      end
   end

   assign clr_cmd_rdy = clr_cmd_q;
   assign clr_ID_vld  = clr_id_q;
   assign go          = go_q;
   assign arrived     = arrived_q;
   assign buzz        = buzz_q;
   assign timeout     = timeout_q;
   assign bad_cmd     = bad_cmd_q;
   assign dest        = dest_q;

endmodule

// File: tb/tb_station_nav_ctrl.sv
// Bench for station_nav_ctrl: a cycle model pushes expected outputs each edge,
// a negedge checker pops and compares; directed checks cover pulse counts and lengths.
module tb_station_nav_ctrl;

   localparam int TO_W     = 4;
   localparam int BUZZ_CYC = 50;
   localparam int TO_MAX   = (1 << TO_W) - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_rdy = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       ID_vld = 1'b0;
   logic [7:0] ID = 8'h00;
   logic       clr_cmd_rdy, clr_ID_vld, go, arrived, buzz, timeout, bad_cmd;
   logic [5:0] dest;

   station_nav_ctrl #(.TO_W(TO_W), .BUZZ_CYC(BUZZ_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
      .ID_vld(ID_vld), .ID(ID), .clr_ID_vld(clr_ID_vld),
      .go(go), .arrived(arrived), .buzz(buzz), .timeout(timeout),
      .bad_cmd(bad_cmd), .dest(dest)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model, evaluated at each posedge from the inputs it sees.
   logic [31:0] sb[$];
   logic        m_clr_cmd = 0, m_clr_id = 0, m_go = 0, m_arr = 0, m_to = 0, m_bad = 0;
   logic [5:0]  m_dest = 0;
   int          m_cnt = 0, m_left = 0;

   always @(posedge clk) begin
      logic ct, it;
      if (!rst_n) begin
         m_clr_cmd = 0; m_clr_id = 0; m_go = 0; m_arr = 0; m_to = 0; m_bad = 0;
         m_dest = 0; m_cnt = 0; m_left = 0;
      end else begin
         ct = cmd_rdy && !m_clr_cmd;
         it = ID_vld && !m_clr_id;
         m_clr_cmd = ct;
         m_clr_id  = it;
         m_arr = 0;
         m_bad = 0;
         if (m_left > 0) m_left--;
         if (ct) begin
            if (cmd[7:6] == 2'b01) begin
               m_dest = cmd[5:0];
               if (!m_go) m_to = 0;
               m_go  = 1;
               m_cnt = 0;
            end else if (cmd[7:6] == 2'b00) begin
               m_go  = 0;
               m_cnt = 0;
            end else begin
               m_bad = 1;
               if (m_go && m_cnt < TO_MAX) m_cnt++;
            end
         end else if (m_go && it && ID[5:0] == m_dest) begin
            m_go = 0; m_arr = 1; m_left = BUZZ_CYC; m_cnt = 0;
         end else if (m_go && it) begin
            m_cnt = 0;
         end else if (m_go && m_cnt == TO_MAX) begin
            m_go = 0; m_to = 1; m_cnt = 0;
         end else if (m_go) begin
            m_cnt++;
         end
      end
      sb.push_back({19'd0, m_clr_cmd, m_clr_id, m_go, m_arr, (m_left != 0), m_to, m_bad, m_dest});
   end

   int n_arr = 0, n_bad = 0, go_run = 0, last_go = 0, bz_run = 0, last_bz = 0;

   always @(negedge clk) begin
      logic [31:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("outs", {19'd0, clr_cmd_rdy, clr_ID_vld, go, arrived, buzz, timeout, bad_cmd, dest}, e);
      end
      if (arrived === 1'b1) n_arr++;
      if (bad_cmd === 1'b1) n_bad++;
      if (go === 1'b1) go_run++;
      else if (go_run > 0) begin last_go = go_run; go_run = 0; end
      if (buzz === 1'b1) bz_run++;
      else if (bz_run > 0) begin last_bz = bz_run; bz_run = 0; end
   end

   // Raise flags like the upstream blocks do: hold each until the edge after its clear.
   task automatic present(input logic dc, input logic [7:0] c, input logic di, input logic [7:0] id,
                          output int nc, output int ni);
      logic cd, idp;
      cd = 0; idp = 0; nc = 0; ni = 0;
      cmd_rdy = dc; cmd = c; ID_vld = di; ID = id;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (cd)  cmd_rdy = 1'b0;
         if (idp) ID_vld  = 1'b0;
         if (clr_cmd_rdy === 1'b1) begin nc++; cd = 1; end
         if (clr_ID_vld === 1'b1)  begin ni++; idp = 1; end
      end
      cmd_rdy = 1'b0; ID_vld = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
   endtask

   int nc, ni, a0, b0;

   initial begin
      cycles(3);
      chk("reset_go", {31'd0, go}, 0);
      rst_n = 1'b1;
      cycles(1);

      // 1: GO dest 5, wrong ID, right ID, buzzer length
      present(1, 8'h45, 0, 8'h00, nc, ni);
      chk("t1_clr_cmd", nc, 1);
      chk("t1_go_dest", {25'd0, go, dest}, {25'd0, 1'b1, 6'd5});
      present(0, 8'h00, 1, 8'h03, nc, ni);
      chk("t1_clr_id", ni, 1);
      chk("t1_go_held", {31'd0, go}, 1);
      a0 = n_arr;
      present(0, 8'h00, 1, 8'h05, nc, ni);
      chk("t1_arrive", n_arr - a0, 1);
      chk("t1_go_off", {31'd0, go}, 0);
      cycles(55);
      chk("t1_buzz_len", last_bz, BUZZ_CYC);

      // 2: STOP while moving, then matching ID in idle
      present(1, 8'h45, 0, 8'h00, nc, ni);
      present(1, 8'h00, 0, 8'h00, nc, ni);
      chk("t2_stop_go", {31'd0, go}, 0);
      a0 = n_arr;
      present(0, 8'h00, 1, 8'h05, nc, ni);
      chk("t2_clr_id", ni, 1);
      chk("t2_no_arrive", n_arr - a0, 0);

      // 3: timeout after 2**TO_W moving cycles, cleared by next GO
      present(1, 8'h41, 0, 8'h00, nc, ni);
      cycles(20);
      chk("t3_timeout", {30'd0, go, timeout}, {30'd0, 2'b01});
      chk("t3_go_len", last_go, TO_MAX + 1);
      present(1, 8'h41, 0, 8'h00, nc, ni);
      chk("t3_rego", {30'd0, go, timeout}, {30'd0, 2'b10});
      present(1, 8'h00, 0, 8'h00, nc, ni);

      // 4: GO and matching ID in the same cycle
      present(1, 8'h45, 0, 8'h00, nc, ni);
      a0 = n_arr;
      present(1, 8'h47, 1, 8'h05, nc, ni);
      chk("t4_clrs", {nc[15:0], ni[15:0]}, {16'd1, 16'd1});
      chk("t4_dest", {31'd0, go}, 1);
      chk("t4_dest7", {26'd0, dest}, 32'd7);
      chk("t4_no_arrive", n_arr - a0, 0);
      present(1, 8'h00, 0, 8'h00, nc, ni);

      // 5: reserved opcode in idle and while moving
      b0 = n_bad;
      present(1, 8'hC2, 0, 8'h00, nc, ni);
      chk("t5_clr_once", nc, 1);
      chk("t5_bad_idle", n_bad - b0, 1);
      chk("t5_go_idle", {31'd0, go}, 0);
      present(1, 8'h45, 0, 8'h00, nc, ni);
      present(1, 8'hC2, 0, 8'h00, nc, ni);
      chk("t5_bad_mov", n_bad - b0, 2);
      chk("t5_go_mov", {31'd0, go}, 1);

      // 6: arrival, new mission with buzzer running, then reset
      present(0, 8'h00, 1, 8'h05, nc, ni);
      present(1, 8'h46, 0, 8'h00, nc, ni);
      chk("t6_pre", {30'd0, go, buzz}, {30'd0, 2'b11});
      rst_n = 1'b0;
      cycles(1);
      chk("t6_reset", {19'd0, clr_cmd_rdy, clr_ID_vld, go, arrived, buzz, timeout, bad_cmd, dest}, 0);
      rst_n = 1'b1;
      cycles(3);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
